// File: rtl/panda_fetch_buffer.sv
// Instruction fetch front-end: issues word fetches over req/gnt/rvalid, buffers
// returned words with their PCs in an in-order FIFO and flushes on redirect.
module panda_fetch_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   redirect_pc;
  logic          granted;
  logic          resp_ok;
  logic          push;
  logic          pop;

  // Every granted-but-unanswered fetch reserves a FIFO slot, so responses
  // can always be accepted without backpressure.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign instr_req_o = !rst_i && !redirect_i && (credit_used < DEPTH_C);
  assign instr_addr_o = fetch_pc;

  assign granted = instr_req_o && instr_gnt_i;
  assign resp_ok = instr_rvalid_i && (outstanding != '0);
  assign push    = resp_ok && (discard == '0) && !redirect_i;
  assign pop     = instr_valid_o && instr_ready_i && !redirect_i;

  assign outstanding_nxt = outstanding + CW'(granted) - CW'(resp_ok);
  assign redirect_pc     = redirect_pc_i & PC_MASK;

  assign instr_valid_o = !rst_i && (count != '0);
  assign instr_o       = word_mem[rd_ptr];
  assign instr_pc_o    = pc_mem[rd_ptr];

  // Control state: fetch/response PCs, credit counters, FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= BOOT_ADDR & PC_MASK;
      resp_pc     <= BOOT_ADDR & PC_MASK;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_i) begin
      // Whatever is still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding_nxt;
      discard     <= outstanding_nxt;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (granted) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding_nxt;
      if (resp_ok && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      word_mem[wr_ptr] <= instr_rdata_i;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory-side protocol error.
  rvalid_without_request: assert property (
    @(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_panda_fetch_buffer.sv
// Directed bench for panda_fetch_buffer: an in-order memory model drives the
// fetch bus and a queue-based reference model is compared every cycle.
module tb_panda_fetch_buffer;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  panda_fetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;

  mreq_t       mem_q[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fetch, m_resp;
  int          m_inflight, m_discard;
  logic [31:0] got_pcs[$];
  logic [31:0] gnt_addrs[$];

  int          cyc, lat;
  logic        gnt_en;
  logic        arm;
  logic [31:0] arm_addr, arm_pc;
  int          n_checks, n_err;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] wfn(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
    if (idx < q.size()) check(name, q[idx], exp);
    else begin
      n_checks++;
      n_err++;
      $display("FAIL %s: only %0d entries, expected entry %0d = %h", name, q.size(), idx, exp);
    end
  endtask

  // One clock cycle: drive memory side, compare against the model, advance both.
  task automatic step();
    logic        rv, rv_ok, exp_req, exp_valid;
    logic [31:0] rd;
    mreq_t       e;
    rv = 1'b0;
    rd = '0;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = wfn(mem_q[0].addr);
    end
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    instr_gnt_i    = gnt_en;
    if (arm && rv && mem_q[0].addr == arm_addr) begin
      redirect_i    = 1'b1;
      redirect_pc_i = arm_pc;
      arm           = 1'b0;
    end
    #1;
    s_req   = instr_req_o;
    s_addr  = instr_addr_o;
    s_valid = instr_valid_o;
    s_pc    = instr_pc_o;
    s_instr = instr_o;

    exp_req   = !rst && !redirect_i && ((m_inflight + int'(m_fifo.size())) < DEPTH);
    exp_valid = !rst && (m_fifo.size() != 0);
    check("req", 32'(s_req), 32'(exp_req));
    if (exp_req) check("addr", s_addr, m_fetch);
    check("valid", 32'(s_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("instr", s_instr, m_fifo[0].word);
      check("pc", s_pc, m_fifo[0].pc);
    end

    if (rst) mem_q.delete();
    else begin
      if (rv) void'(mem_q.pop_front());
      if (s_req && gnt_en) begin
        e.addr = s_addr;
        e.due  = cyc + lat;
        mem_q.push_back(e);
      end
    end

    rv_ok = rv && (m_inflight > 0);
    if (rst) begin
      m_fetch = BOOT; m_resp = BOOT; m_inflight = 0; m_discard = 0;
      m_fifo.delete();
    end else if (redirect_i) begin
      if (rv_ok) m_inflight--;
      m_discard = m_inflight;
      m_fifo.delete();
      m_fetch = redirect_pc_i & 32'hFFFF_FFFC;
      m_resp  = m_fetch;
    end else begin
      if (exp_valid && instr_ready_i) begin
        got_pcs.push_back(m_fifo[0].pc);
        void'(m_fifo.pop_front());
      end
      if (exp_req && gnt_en) begin
        gnt_addrs.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
        m_inflight++;
      end
      if (rv_ok) begin
        m_inflight--;
        if (m_discard > 0) m_discard--;
        else begin
          m_fifo.push_back('{word: rd, pc: m_resp});
          m_resp = m_resp + 32'd4;
        end
      end
    end

    @(negedge clk);
    redirect_i = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arm = 1'b0;
    step();
    rst = 1'b0;
    got_pcs.delete();
    gnt_addrs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n8;
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    gnt_en = 1'b0; lat = 1; arm = 1'b0; arm_addr = '0; arm_pc = '0; cyc = 0;
    n_checks = 0; n_err = 0;
    m_fetch = BOOT; m_resp = BOOT; m_inflight = 0; m_discard = 0;

    // Streaming fetch
    step();
    check("rst_req", 32'(s_req), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    step();
    rst = 1'b0; gnt_en = 1'b1; lat = 1; instr_ready_i = 1'b1;
    got_pcs.delete(); gnt_addrs.delete();
    step();
    check("t1_c0_addr", s_addr, 32'h0);
    step();
    check("t1_c1_valid", 32'(s_valid), 32'd0);
    step();
    check("t1_c2_valid", 32'(s_valid), 32'd1);
    check("t1_c2_pc", s_pc, 32'h0);
    check("t1_c2_instr", s_instr, 32'hFFFF_0000);
    repeat (9) step();
    check_q("t1_seq0", got_pcs, 0, 32'h0);
    check_q("t1_seq1", got_pcs, 1, 32'h4);
    check_q("t1_seq2", got_pcs, 2, 32'h8);
    check_q("t1_seq3", got_pcs, 3, 32'hC);

    // Backpressure
    instr_ready_i = 1'b0; gnt_en = 1'b1; lat = 1;
    do_reset();
    repeat (6) step();
    check("t2_full_valid", 32'(s_valid), 32'd1);
    check("t2_full_pc", s_pc, 32'h0);
    check("t2_full_req", 32'(s_req), 32'd0);
    instr_ready_i = 1'b1;
    repeat (8) step();
    check_q("t2_seq0", got_pcs, 0, 32'h0);
    check_q("t2_seq1", got_pcs, 1, 32'h4);
    check_q("t2_seq2", got_pcs, 2, 32'h8);

    // Redirect with two fetches in flight
    instr_ready_i = 1'b1; lat = 3;
    do_reset();
    step();
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step();
    check("t3_redir_req", 32'(s_req), 32'd0);
    got_pcs.delete();
    for (int i = 0; i < 10 && !s_req; i++) step();
    check("t3_req_after", 32'(s_req), 32'd1);
    check("t3_addr_after", s_addr, 32'h0000_0100);
    repeat (10) step();
    check_q("t3_seq0", got_pcs, 0, 32'h0000_0100);
    check_q("t3_seq1", got_pcs, 1, 32'h0000_0104);

    // Redirect coinciding with the response for 0x8
    instr_ready_i = 1'b1; lat = 3;
    do_reset();
    arm = 1'b1; arm_addr = 32'h8; arm_pc = 32'h200;
    repeat (16) step();
    check("t4_fired", 32'(arm), 32'd0);
    check_q("t4_seq0", got_pcs, 0, 32'h0);
    check_q("t4_seq1", got_pcs, 1, 32'h4);
    check_q("t4_seq2", got_pcs, 2, 32'h200);
    n8 = 0;
    foreach (got_pcs[i]) if (got_pcs[i] == 32'h8) n8++;
    check("t4_no_0x8", 32'(n8), 32'd0);

    // Grant stall, then address wrap
    instr_ready_i = 1'b1; lat = 1; gnt_en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_stall_req", 32'(s_req), 32'd1);
      check("t5_stall_addr", s_addr, 32'h0);
    end
    gnt_en = 1'b1;
    repeat (4) step();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    got_pcs.delete(); gnt_addrs.delete();
    repeat (8) step();
    check_q("t5_gnt0", gnt_addrs, 0, 32'hFFFF_FFFC);
    check_q("t5_gnt1", gnt_addrs, 1, 32'h0000_0000);
    check_q("t5_seq0", got_pcs, 0, 32'hFFFF_FFFC);
    check_q("t5_seq1", got_pcs, 1, 32'h0000_0000);

    // Mid-run reset while full
    instr_ready_i = 1'b0; lat = 1; gnt_en = 1'b1;
    do_reset();
    repeat (6) step();
    check("t6_full_valid", 32'(s_valid), 32'd1);
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(s_valid), 32'd0);
    check("t6_rst_req", 32'(s_req), 32'd0);
    rst = 1'b0; instr_ready_i = 1'b1;
    got_pcs.delete();
    step();
    check("t6_boot_req", 32'(s_req), 32'd1);
    check("t6_boot_addr", s_addr, BOOT);
    repeat (6) step();
    check_q("t6_seq0", got_pcs, 0, BOOT);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/panda_fetch_buffer.md
Name: panda_fetch_buffer

Overview:
Instruction fetch front-end that produces the 32-bit instruction word and its PC consumed by the decode stage. It issues word fetches to instruction memory over a req/gnt/rvalid interface and buffers returned words in a small in-order FIFO. It presents them to decode with a valid/ready handshake. On a redirect (taken branch or jump), it flushes buffered and in-flight instructions and refetches from the new PC.

Parameters:
DEPTH, 2, FIFO entries and maximum outstanding fetches; power of two, at least 2.
BOOT_ADDR, 32'h0000_0000, first fetch PC after reset; bits [1:0] must be 0.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous reset, active-high
instr_req_o  output  1  fetch request valid
instr_gnt_i  input  1  memory accepts the request this cycle
instr_addr_o  output  32  fetch word address, bits [1:0] always 0
instr_rvalid_i  input  1  read data valid; responses return in request order, at least 1 cycle after gnt
instr_rdata_i  input  32  returned instruction word
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  new fetch PC; bits [1:0] are ignored and forced to 0
instr_valid_o  output  1  instr_o and instr_pc_o are valid
instr_o  output  32  instruction word to decode
instr_pc_o  output  32  PC of instr_o
instr_ready_i  input  1  decode consumes the head entry when instr_valid_o is also high

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next accepted response.
  - outstanding: granted requests with no response yet; width $clog2(DEPTH)+1.
  - discard: responses still to be dropped; same width.
  - FIFO of {word, pc}, with occupancy count.
- Reset values: fetch_pc = resp_pc = BOOT_ADDR; outstanding, discard and occupancy = 0; instr_valid_o = 0; instr_req_o = 0 during the reset cycle. instr_o and instr_pc_o are don't-care while instr_valid_o = 0.
- Request rule: instr_req_o = !rst_i && !redirect_i && (outstanding + occupancy < DEPTH). instr_addr_o = fetch_pc.
- Grant: on instr_req_o && instr_gnt_i, fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
- Request holding: an un-granted request holds its address stable unless a redirect occurs. A redirect may retract or change an un-granted request.
- Response: on instr_rvalid_i, outstanding decrements.
  - If discard > 0: discard decrements and the word is dropped.
  - Otherwise: push {instr_rdata_i, resp_pc} and resp_pc += 4.
  - The credit rule guarantees a free FIFO slot; no backpressure on rvalid.
- rvalid while outstanding = 0 is a protocol error: ignore it, and a simulation assertion fires.
- Output timing: instr_valid_o = (occupancy != 0); the head entry drives instr_o and instr_pc_o.
  - FIFO output is registered: a word returned with rvalid in cycle N is visible at the outputs in cycle N+1.
  - Minimum fetch-to-decode latency is 2 cycles with single-cycle memory.
- Pop: on instr_valid_o && instr_ready_i. Simultaneous push and pop in one cycle keeps occupancy unchanged.
- Redirect (priority over every other event in the same cycle):
  - FIFO cleared; instr_valid_o = 0 in cycle N+1.
  - fetch_pc = resp_pc = {redirect_pc_i[31:2], 2'b00}.
  - discard = outstanding minus (1 if rvalid this cycle); the rvalid word in the redirect cycle is dropped.
  - No request issued in the redirect cycle.
  - A pop in the redirect cycle has no further effect.
- Back-to-back redirects: each one recomputes discard from the current outstanding; the last PC wins.
- Full: occupancy = DEPTH with instr_ready_i = 0 holds instr_req_o low. Entries hold stable until popped or flushed.
- Stall semantics: instr_valid_o, once high, stays high with stable instr_o and instr_pc_o until a pop, a redirect or reset.
- Reset mid-operation: all state returns to reset values. The memory side is reset in the same cycle, so no stale responses are expected.

Test Plan:
- Streaming fetch: DEPTH=2; reset release, memory grants immediately with 1-cycle rvalid, ready held high -> addresses 0x0, 0x4, 0x8... Decode sees pc 0x0 in cycle 2, then one instruction per cycle with matching words.
- Backpressure: ready=0 for 5 cycles -> occupancy reaches 2 and instr_req_o drops. instr_o stays at pc 0x0. On ready=1, pcs 0x0, 0x4, 0x8 are delivered in order with none lost or duplicated.
- Redirect with in-flight fetches: memory latency 3 cycles, 2 outstanding; redirect_i=1 with redirect_pc_i=0x0000_0103 -> next address 0x100. Both stale responses are dropped, and the first instr_pc_o after the redirect is 0x100.
- Redirect in the cycle rvalid arrives: redirect coincides with rvalid for pc 0x8 -> the 0x8 word never appears at the output, and discard equals the remaining outstanding count.
- Grant stall and wrap: gnt held low 4 cycles -> instr_addr_o stable. Then with fetch_pc=0xFFFF_FFFC, the next address is 0x0000_0000.
- Mid-run reset: rst_i pulsed while FIFO full -> instr_valid_o=0 and instr_req_o=0 in the reset cycle. The next request is to BOOT_ADDR.
